flash_read_sched: RTL and testbench



---
 rtl/flash_read_sched_pkg.sv | 39 +++
 rtl/flash_read_sched_if.sv | 30 +++
 rtl/flash_read_sched_timer.sv | 36 +++
 rtl/flash_read_sched.sv | 189 ++++++++++++++++++
 tb/tb_flash_read_sched.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/flash_read_sched_pkg.sv
// Shared types and defaults for the flash burst scheduler; no logic, no latency.
// Timing defaults come from the read engine's define set so both blocks agree.
`ifndef FLASH_TIMING_DEFS
`define FLASH_TIMING_DEFS
`define FLASH_BURST_WORDS 2070
`define FLASH_ENG_GAP 16
`define FLASH_TIMEOUT_CYC 65535
`define FLASH_RST_HOLD 4
`endif

package flash_pkg;

  localparam int ADDR_W_DEF      = 25;
  localparam int FREE_W_DEF      = 16;
  localparam int BURST_WORDS_DEF = `FLASH_BURST_WORDS;
  localparam int ENG_GAP_DEF     = `FLASH_ENG_GAP;
  localparam int TIMEOUT_CYC_DEF = `FLASH_TIMEOUT_CYC;
  localparam int RST_HOLD_DEF    = `FLASH_RST_HOLD;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP,
    ST_ABORT,
    ST_FIN
  } sched_state_e;

  // Counter width large enough to hold the largest of the three load values.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/flash_read_sched_if.sv
// Frame-control and engine-side signals of the burst scheduler; slave = scheduler.
// Level/pulse signalling only; backpressure is the fifo_free threshold.
interface flash_read_sched_if #(
  parameter int ADDR_W = 25,
  parameter int FREE_W = 16
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [7:0]        n_burst;
  logic              stop;
  logic [FREE_W-1:0] fifo_free;
  logic              read_done;
  logic              read_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              eng_rst_n;
  logic              busy;
  logic              done;
  logic              err;
  logic [7:0]        cur_burst;

  modport slave (
    input  start, base_addr, n_burst, stop, fifo_free, read_done,
    output read_en, rd_addr, eng_rst_n, busy, done, err, cur_burst
  );

  modport master (
    output start, base_addr, n_burst, stop, fifo_free, read_done,
    input  read_en, rd_addr, eng_rst_n, busy, done, err, cur_burst
  );
endinterface

// File: rtl/flash_read_sched_timer.sv
// Loadable down-counter with zero flag, shared by gap, abort hold and timeout.
// Load wins over decrement; decrement saturates at zero; no backpressure.
module flash_sched_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/flash_read_sched.sv
// Frame burst scheduler: one engine read per burst, stuck-engine timeout and reset.
// read_en two cycles after start; holds in CHECK while fifo_free < one burst.
module flash_read_sched
  import flash_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int BURST_WORDS = BURST_WORDS_DEF,
  parameter int FREE_W      = FREE_W_DEF,
  parameter int ENG_GAP     = ENG_GAP_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int RST_HOLD    = RST_HOLD_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  flash_read_sched_if.slave  bus
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYC, ENG_GAP, RST_HOLD);
  localparam logic [CNT_W-1:0]  TO_LOAD   = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(ENG_GAP - 1);
  localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(RST_HOLD - 1);
  localparam logic [FREE_W-1:0] FREE_MIN  = FREE_W'(BURST_WORDS);
  localparam logic [ADDR_W-1:0] ADDR_INC  = ADDR_W'(BURST_WORDS);

  sched_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]        nb_q, nb_d;
  logic [7:0]        cur_q, cur_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              rd_en_q, rd_en_d;
  logic              eng_rst_n_q, eng_rst_n_d;
  logic              stop_lat_q, stop_lat_d;
  logic              rd_prev_q;
  logic              rd_rise;

  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_dec;
  logic              tmr_zero;

  assign rd_rise = bus.read_done & ~rd_prev_q;

  flash_sched_timer #(.W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rd_addr_d   = rd_addr_q;
    nb_d        = nb_q;
    cur_d       = cur_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    rd_en_d     = 1'b0;
    eng_rst_n_d = 1'b1;
    stop_lat_d  = stop_lat_q;
    tmr_load    = 1'b0;
    tmr_val     = GAP_LOAD;
    tmr_dec     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          addr_d     = bus.base_addr;
          nb_d       = bus.n_burst;
          busy_d     = 1'b1;
          err_d      = 1'b0;
          cur_d      = '0;
          stop_lat_d = 1'b0;
          state_d    = (bus.n_burst == '0) ? ST_FIN : ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (bus.stop) begin
          state_d = ST_FIN;
        end else if (bus.fifo_free >= FREE_MIN) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        rd_en_d   = 1'b1;
        rd_addr_d = addr_q;
        tmr_load  = 1'b1;
        tmr_val   = TO_LOAD;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.stop) begin
          stop_lat_d = 1'b1;
        end
        // A completion seen on the expiry cycle still counts as success.
        if (rd_rise) begin
          cur_d    = cur_q + 8'd1;
          addr_d   = addr_q + ADDR_INC;
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
          state_d  = ST_GAP;
        end else if (tmr_zero) begin
          err_d    = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LOAD;
          state_d  = ST_ABORT;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_GAP: begin
        if (tmr_zero) begin
          state_d = ((cur_q == nb_q) || stop_lat_q || err_q) ? ST_FIN : ST_CHECK;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_ABORT: begin
        eng_rst_n_d = 1'b0;
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
          state_d  = ST_GAP;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      rd_addr_q   <= '0;
      nb_q        <= '0;
      cur_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_en_q     <= 1'b0;
      eng_rst_n_q <= 1'b1;
      stop_lat_q  <= 1'b0;
      rd_prev_q   <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      rd_addr_q   <= rd_addr_d;
      nb_q        <= nb_d;
      cur_q       <= cur_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rd_en_q     <= rd_en_d;
      eng_rst_n_q <= eng_rst_n_d;
      stop_lat_q  <= stop_lat_d;
      rd_prev_q   <= bus.read_done;
    end
  end

  assign bus.read_en   = rd_en_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.eng_rst_n = eng_rst_n_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.cur_burst = cur_q;

endmodule

// File: tb/tb_flash_read_sched.sv
// Directed bench for flash_read_sched: table of frame vectors plus hand sequences.
`timescale 1ns/1ps
module tb_flash_read_sched;

  localparam int TO  = 600;
  localparam int GAP = 16;
  localparam int EV_NONE  = 0;
  localparam int EV_STOP  = 1;
  localparam int EV_START = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  flash_read_sched_if #(.ADDR_W(25), .FREE_W(16)) bus_if ();

  flash_read_sched #(.TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef struct {
    logic [24:0] base;
    logic [7:0]  nb;
    logic [15:0] fifo;
    int          dly;
    int          ev;
    int          ev_at;
    bit          sws;
    int          exp_rd;
    int          exp_cur;
    int          exp_err;
    int          exp_rstlow;
    logic [24:0] a0, a1, a2;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int eng_dly = -1;
  bit eng_busy = 1'b0;

  int rd_cnt = 0, done_cnt = 0, rstlow_cnt = 0, en_long = 0, done_cyc = 0, rise_cnt = 0;
  bit en_prev = 1'b0;
  logic [24:0] rd_log[0:63];
  int rd_cyc_log[0:63];
  int rise_log[0:63];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus_if.read_en) begin
      if (rd_cnt < 64) begin
        rd_log[rd_cnt]     = bus_if.rd_addr;
        rd_cyc_log[rd_cnt] = cyc;
      end
      rd_cnt = rd_cnt + 1;
      if (en_prev) en_long = en_long + 1;
    end
    en_prev = bus_if.read_en;
    if (bus_if.done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (!bus_if.eng_rst_n) rstlow_cnt = rstlow_cnt + 1;
  end

  // Engine model: completes eng_dly cycles after read_en, holds read_done 12 cycles.
  initial begin
    bus_if.read_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_if.read_en && eng_dly >= 0) begin
        eng_busy = 1'b1;
        repeat (eng_dly) @(posedge clk);
        #1 bus_if.read_done = 1'b1;
        if (rise_cnt < 64) rise_log[rise_cnt] = cyc;
        rise_cnt = rise_cnt + 1;
        repeat (12) @(posedge clk);
        #1 bus_if.read_done = 1'b0;
        eng_busy = 1'b0;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec = n_vec + 1;
    if (act != exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [24:0] base, input logic [7:0] nb, input logic [15:0] fifo,
                              input int dly, input int ev, input int ev_at, input bit sws,
                              input int exp_rd, input int exp_cur, input int exp_err, input int exp_rstlow,
                              input logic [24:0] a0, input logic [24:0] a1, input logic [24:0] a2);
    vec_t v;
    v.base = base; v.nb = nb; v.fifo = fifo; v.dly = dly; v.ev = ev; v.ev_at = ev_at; v.sws = sws;
    v.exp_rd = exp_rd; v.exp_cur = exp_cur; v.exp_err = exp_err; v.exp_rstlow = exp_rstlow;
    v.a0 = a0; v.a1 = a1; v.a2 = a2;
    return v;
  endfunction

  task automatic wait_engine_idle();
    int b;
    b = 0;
    while (eng_busy && b < 200) begin
      @(posedge clk);
      b++;
    end
    check("engine_idle", int'(eng_busy), 0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int k, rb, db, lb, eb, budget;
    bit poked;
    logic [24:0] ea[3];
    ea[0] = v.a0; ea[1] = v.a1; ea[2] = v.a2;
    rb = rd_cnt; db = done_cnt; lb = rstlow_cnt; eb = rise_cnt;
    bus_if.base_addr = v.base;
    bus_if.n_burst   = v.nb;
    bus_if.fifo_free = v.fifo;
    eng_dly          = v.dly;
    @(posedge clk); #1;
    bus_if.start = 1'b1;
    bus_if.stop  = v.sws;
    @(posedge clk); #1;
    k = cyc;
    bus_if.start = 1'b0;
    bus_if.stop  = 1'b0;
    check($sformatf("v%0d_busy_after_start", idx), int'(bus_if.busy), 1);
    budget = 0;
    poked  = 1'b0;
    while (done_cnt == db && budget < 4000) begin
      @(posedge clk); #1;
      budget++;
      if (v.ev != EV_NONE && !poked && (rd_cnt - rb) == v.ev_at) begin
        poked = 1'b1;
        if (v.ev == EV_STOP) begin
          bus_if.stop = 1'b1;
        end else begin
          bus_if.base_addr = 25'h0005555;
          bus_if.n_burst   = 8'd7;
          bus_if.start     = 1'b1;
        end
        @(posedge clk); #1;
        bus_if.stop  = 1'b0;
        bus_if.start = 1'b0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    check($sformatf("v%0d_done_pulses", idx), done_cnt - db, 1);
    check($sformatf("v%0d_reads", idx), rd_cnt - rb, v.exp_rd);
    check($sformatf("v%0d_cur_burst", idx), int'(bus_if.cur_burst), v.exp_cur);
    check($sformatf("v%0d_err", idx), int'(bus_if.err), v.exp_err);
    check($sformatf("v%0d_busy_end", idx), int'(bus_if.busy), 0);
    check($sformatf("v%0d_rst_low_cycles", idx), rstlow_cnt - lb, v.exp_rstlow);
    for (int i = 0; i < 3; i++) begin
      if (i < v.exp_rd && (rb + i) < 64)
        check($sformatf("v%0d_rd_addr%0d", idx, i), int'(rd_log[rb + i]), int'(ea[i]));
    end
    if (v.nb == 8'd0) begin
      check($sformatf("v%0d_done_latency", idx), done_cyc, k + 1);
    end else if (v.exp_rd > 0 && rb < 64) begin
      check($sformatf("v%0d_first_read_latency", idx), rd_cyc_log[rb], k + 2);
    end
    if (v.exp_err == 0 && v.exp_rd > 0 && rise_cnt > eb && rise_cnt <= 64)
      check($sformatf("v%0d_done_after_last_rise", idx), done_cyc, rise_log[rise_cnt - 1] + GAP + 2);
    if (v.exp_rd > 1 && (rb + 1) < 64 && eb < 64)
      check($sformatf("v%0d_read_spacing", idx), rd_cyc_log[rb + 1], rise_log[eb] + GAP + 3);
    wait_engine_idle();
  endtask

  vec_t vecs[9];

  initial begin
    int b, sc;
    bit seen;
    bus_if.start     = 1'b0;
    bus_if.stop      = 1'b0;
    bus_if.base_addr = '0;
    bus_if.n_burst   = '0;
    bus_if.fifo_free = 16'd4096;

    vecs[0] = mk(25'h0000100,   8'd3, 16'd4096, 500, EV_NONE,  0, 1'b0, 3, 3, 0, 0, 25'h0000100, 25'h0000916, 25'h000112C);
    vecs[1] = mk(25'h1FFFC00,   8'd2, 16'd4096,  40, EV_NONE,  0, 1'b0, 2, 2, 0, 0, 25'h1FFFC00, 25'h0000416, 25'h0);
    vecs[2] = mk(25'h0000300,   8'd2, 16'd4096,  -1, EV_NONE,  0, 1'b0, 1, 0, 1, 4, 25'h0000300, 25'h0,       25'h0);
    vecs[3] = mk(25'h0000040,   8'd1, 16'd4096,  TO, EV_NONE,  0, 1'b0, 1, 1, 0, 0, 25'h0000040, 25'h0,       25'h0);
    vecs[4] = mk(25'h0000000,   8'd5, 16'd4096,  60, EV_STOP,  2, 1'b0, 2, 2, 0, 0, 25'h0000000, 25'h0000816, 25'h0);
    vecs[5] = mk(25'h0000ABC,   8'd0, 16'd4096,  20, EV_NONE,  0, 1'b0, 0, 0, 0, 0, 25'h0,       25'h0,       25'h0);
    vecs[6] = mk(25'h0000200,   8'd2, 16'd4096,  30, EV_START, 1, 1'b0, 2, 2, 0, 0, 25'h0000200, 25'h0000A16, 25'h0);
    vecs[7] = mk(25'h0000007,   8'd1, 16'd4096,  20, EV_NONE,  0, 1'b1, 1, 1, 0, 0, 25'h0000007, 25'h0,       25'h0);
    vecs[8] = mk(25'h0000010,   8'd1, 16'd2070,  20, EV_NONE,  0, 1'b0, 1, 1, 0, 0, 25'h0000010, 25'h0,       25'h0);

    repeat (2) @(posedge clk);
    #1;
    check("rst_read_en", int'(bus_if.read_en), 0);
    check("rst_rd_addr", int'(bus_if.rd_addr), 0);
    check("rst_eng_rst_n", int'(bus_if.eng_rst_n), 1);
    check("rst_busy", int'(bus_if.busy), 0);
    check("rst_done", int'(bus_if.done), 0);
    check("rst_err", int'(bus_if.err), 0);
    check("rst_cur_burst", int'(bus_if.cur_burst), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // FIFO one word short of a burst holds the scheduler in CHECK.
    begin
      int rb, db;
      rb = rd_cnt; db = done_cnt;
      bus_if.base_addr = 25'h0000500;
      bus_if.n_burst   = 8'd1;
      bus_if.fifo_free = 16'd2069;
      eng_dly          = 20;
      @(posedge clk); #1 bus_if.start = 1'b1;
      @(posedge clk); #1 bus_if.start = 1'b0;
      repeat (1000) @(posedge clk);
      #1;
      check("fifo_short_no_read", rd_cnt - rb, 0);
      check("fifo_short_busy", int'(bus_if.busy), 1);
      bus_if.fifo_free = 16'd2070;
      sc = cyc;
      b = 0;
      while (rd_cnt == rb && b < 50) begin
        @(posedge clk); #1;
        b++;
      end
      check("fifo_ok_read_seen", rd_cnt - rb, 1);
      if (rb < 64) check("fifo_ok_read_latency", rd_cyc_log[rb], sc + 2);
      if (rb < 64) check("fifo_ok_rd_addr", int'(rd_log[rb]), 32'h500);
      b = 0;
      while (done_cnt == db && b < 200) begin
        @(posedge clk); #1;
        b++;
      end
      check("fifo_ok_done", done_cnt - db, 1);
      wait_engine_idle();
    end

    // Reset asserted while read_en is high must drop every output at once.
    eng_dly          = -1;
    bus_if.fifo_free = 16'd4096;
    bus_if.base_addr = 25'h0000123;
    bus_if.n_burst   = 8'd3;
    @(posedge clk); #1 bus_if.start = 1'b1;
    @(posedge clk); #1 bus_if.start = 1'b0;
    seen = 1'b0;
    b = 0;
    while (!seen && b < 20) begin
      @(negedge clk);
      b++;
      if (bus_if.read_en) seen = 1'b1;
    end
    check("midrst_read_en_seen", int'(seen), 1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_read_en", int'(bus_if.read_en), 0);
    check("midrst_busy", int'(bus_if.busy), 0);
    check("midrst_rd_addr", int'(bus_if.rd_addr), 0);
    check("midrst_eng_rst_n", int'(bus_if.eng_rst_n), 1);
    check("midrst_cur_burst", int'(bus_if.cur_burst), 0);
    @(posedge clk); #3 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("read_en_single_cycle", en_long, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
